// File: rtl/datapath_pkg.sv
// Shared datapath widths and types for the register file.
package datapath_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32'(1) << ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  // Reset contents of a register: its own index.
  function automatic word_t reset_value(input int unsigned idx);
    return word_t'(idx);
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One read port: address mux with r0 forced to zero, captured on the falling edge.
module rf_read_port
  import datapath_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  word_t regs [NUM_REGS],
  input  logic  [ADDR_W-1:0] addr,
  output logic  [DATA_W-1:0] data
);

  word_t sel_c;

  // Select the addressed register; register 0 always reads as zero.
  always_comb begin
    sel_c = '0;
    if (addr != '0) begin
      sel_c = regs[addr];
    end
  end

  // Capture on negedge so a write committed at the preceding posedge is visible.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      data <= '0;
    end else begin
      data <= sel_c;
    end
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32 register file: one posedge write port, two negedge-captured read ports.
module reg_file
  import datapath_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] PR1,
  input  logic [ADDR_W-1:0] PR2,
  input  logic [ADDR_W-1:0] WR,
  input  logic [DATA_W-1:0] WD,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2
);

  word_t               rf_mem [NUM_REGS];
  logic [NUM_REGS-1:0] we_c;

  // Decode the write address; writes to register 0 never enable anything.
  always_comb begin
    we_c = '0;
    if ((write == 1'b1) && (WR != '0)) begin
      we_c[WR] = 1'b1;
    end
  end

  // Storage: reset reloads index values and discards any concurrent write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_mem[i] <= reset_value(i);
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (we_c[i]) begin
          rf_mem[i] <= WD;
        end
      end
    end
  end

  rf_read_port u_read_port1 (
    .clk   (clk),
    .rst_n (rst_n),
    .regs  (rf_mem),
    .addr  (PR1),
    .data  (RD1)
  );

  rf_read_port u_read_port2 (
    .clk   (clk),
    .rst_n (rst_n),
    .regs  (rf_mem),
    .addr  (PR2),
    .data  (RD2)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic [4:0]  PR1;
  logic [4:0]  PR2;
  logic [4:0]  WR;
  logic [31:0] WD;
  logic [31:0] RD1;
  logic [31:0] RD2;

  int n_checks = 0;
  int n_errors = 0;

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .write (write),
    .PR1   (PR1),
    .PR2   (PR2),
    .WR    (WR),
    .WD    (WD),
    .RD1   (RD1),
    .RD2   (RD2)
  );

  // posedge at 5, 15, ...; negedge at 10, 20, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full cycle: posedge (write), negedge (read), then settle.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; write = 1'b0; PR1 = 5'd0; PR2 = 5'd0; WR = 5'd0; WD = 32'd0;
    cycle();
    cycle();
    check("reset_rd1", RD1, 32'd0);
    check("reset_rd2", RD2, 32'd0);
    rst_n = 1'b1;

    // 1. Initial contents
    PR1 = 5'd6; PR2 = 5'd8;
    cycle();
    check("init_r6", RD1, 32'd6);
    check("init_r8", RD2, 32'd8);
    PR1 = 5'd0; PR2 = 5'd0;
    cycle();
    check("init_r0_p1", RD1, 32'd0);
    check("init_r0_p2", RD2, 32'd0);
    PR1 = 5'd31; PR2 = 5'd17;
    cycle();
    check("init_r31", RD1, 32'd31);
    check("init_r17", RD2, 32'd17);

    // 2. Write then read
    write = 1'b1; WR = 5'd4; WD = 32'd31;
    cycle();
    write = 1'b0; PR1 = 5'd4;
    cycle();
    check("wr_r4", RD1, 32'd31);
    cycle(); cycle(); cycle();
    check("wr_r4_hold", RD1, 32'd31);

    // 3. Half-cycle ordering
    PR1 = 5'd10; PR2 = 5'd12;
    cycle();
    check("ord_r10", RD1, 32'd10);
    check("ord_r12", RD2, 32'd12);
    write = 1'b1; WR = 5'd1; WD = 32'd20; PR1 = 5'd1;
    cycle();
    check("ord_new_r1", RD1, 32'd20);
    write = 1'b0;
    // Read at negedge precedes the write at the next posedge: old value first
    @(posedge clk); #1;
    write = 1'b1; WR = 5'd10; WD = 32'd77; PR1 = 5'd10;
    @(negedge clk); #1;
    check("ord_old_r10", RD1, 32'd10);
    @(posedge clk); #1;
    write = 1'b0;
    @(negedge clk); #1;
    check("ord_after_r10", RD1, 32'd77);

    // 4. Register 0 is hardwired
    write = 1'b1; WR = 5'd0; WD = 32'hDEADBEEF; PR1 = 5'd0; PR2 = 5'd0;
    cycle();
    write = 1'b0;
    cycle();
    check("r0_p1", RD1, 32'd0);
    check("r0_p2", RD2, 32'd0);

    // 5. Reset reloads and discards concurrent write
    PR1 = 5'd4; PR2 = 5'd1;
    cycle();
    check("pre_rst_r4", RD1, 32'd31);
    check("pre_rst_r1", RD2, 32'd20);
    rst_n = 1'b0; write = 1'b1; WR = 5'd5; WD = 32'd99;
    cycle();
    check("rst_rd1", RD1, 32'd0);
    check("rst_rd2", RD2, 32'd0);
    rst_n = 1'b1; write = 1'b0; PR1 = 5'd4; PR2 = 5'd5;
    cycle();
    check("post_rst_r4", RD1, 32'd4);
    check("post_rst_r5", RD2, 32'd5);
    PR1 = 5'd1; PR2 = 5'd10;
    cycle();
    check("post_rst_r1", RD1, 32'd1);
    check("post_rst_r10", RD2, 32'd10);

    // 6. Same address on both ports, disabled write
    PR1 = 5'd7; PR2 = 5'd7;
    cycle();
    check("dual_p1", RD1, 32'd7);
    check("dual_p2", RD2, 32'd7);
    write = 1'b0; WR = 5'd7; WD = 32'd55;
    cycle();
    cycle();
    check("nowr_p1", RD1, 32'd7);
    check("nowr_p2", RD2, 32'd7);

    // Top register write and independence of neighbours
    write = 1'b1; WR = 5'd31; WD = 32'hA5A5_5A5A;
    cycle();
    write = 1'b0; PR1 = 5'd31; PR2 = 5'd30;
    cycle();
    check("r31_new", RD1, 32'hA5A5_5A5A);
    check("r30_same", RD2, 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
